// File: rtl/mem_read_responder.sv
// mem_read_responder: request/grant read target with configurable grant latency and a preload write port
module mem_read_responder #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int MEM_AW  = 8,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read_request,
    input  logic [ADDR_W-1:0] addr_bus,
    output logic              read_grant,
    output logic [DATA_W-1:0] data_bus,
    output logic              data_valid,
    output logic              addr_err,
    input  logic              wr_en,
    input  logic [MEM_AW-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [15:0]       reads_served
);
    typedef enum logic [2:0] {IDLE, WAIT, GRANT, ACCESS, DATA} state_t;
    state_t            state_q;
    logic [3:0]        cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic              grant_q;
    logic              valid_q;
    logic              err_q;
    logic [DATA_W-1:0] data_q;
    logic [15:0]       served_q;
    logic [DATA_W-1:0] mem_q [2**MEM_AW];
    logic              oob_d;
    logic [DATA_W-1:0] word_d;

    // Word delivered on the ACCESS edge: out-of-range reads return 0, a same-cycle preload to the address wins
    always_comb begin
        oob_d  = |addr_q[ADDR_W-1:MEM_AW];
        word_d = oob_d ? '0 : (wr_en && wr_addr == addr_q[MEM_AW-1:0]) ? wr_data : mem_q[addr_q[MEM_AW-1:0]];
    end

    // Preload port, one word per cycle in every state; contents survive reset
    always_ff @(posedge clk)
        if (wr_en) mem_q[wr_addr] <= wr_data;

    // Handshake FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            grant_q  <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            data_q   <= '0;
            served_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (read_request) begin
                        if (LATENCY == 0) begin
                            state_q <= GRANT;
                            grant_q <= 1'b1;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= 4'(LATENCY);
                        end
                    end
                end
                WAIT: begin
                    if (!read_request) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == 4'd1) begin
                        state_q <= GRANT;
                        grant_q <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                GRANT: begin
                    grant_q <= 1'b0;
                    if (read_request) begin
                        state_q  <= ACCESS;
                        addr_q   <= addr_bus;
                        served_q <= served_q + 16'd1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ACCESS: begin
                    state_q <= DATA;
                    data_q  <= word_d;
                    valid_q <= 1'b1;
                    err_q   <= oob_d;
                end
                DATA: begin
                    err_q <= 1'b0;
                    if (!read_request) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        data_q  <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign read_grant   = grant_q;
    assign data_bus     = data_q;
    assign data_valid   = valid_q;
    assign addr_err     = err_q;
    assign reads_served = served_q;
endmodule

// File: tb/tb_mem_read_responder.sv
// tb_mem_read_responder: three responders (LATENCY 1, 0, 4) checked against a transaction-age model
module tb_mem_read_responder;
    localparam int LAT [3] = '{1, 0, 4};

    logic        clk = 1'b0;
    logic        rst;
    logic        req [3];
    logic [15:0] addr;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        grant [3];
    logic        valid [3];
    logic        err [3];
    logic [31:0] data [3];
    logic [15:0] srv [3];

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;
    bit preset = 1'b0;

    bit          m_act [3];
    int          m_age [3];
    logic [15:0] m_addr [3];
    logic [31:0] m_word [3];
    bit          m_err [3];
    logic [15:0] m_srv [3];
    logic [31:0] mmem [256];

    always #5 clk = ~clk;

    mem_read_responder #(.LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .read_request(req[0]), .addr_bus(addr),
        .read_grant(grant[0]), .data_bus(data[0]), .data_valid(valid[0]), .addr_err(err[0]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .reads_served(srv[0])
    );
    mem_read_responder #(.LATENCY(0)) u_l0 (
        .clk(clk), .rst(rst), .read_request(req[1]), .addr_bus(addr),
        .read_grant(grant[1]), .data_bus(data[1]), .data_valid(valid[1]), .addr_err(err[1]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .reads_served(srv[1])
    );
    mem_read_responder #(.LATENCY(4)) u_l4 (
        .clk(clk), .rst(rst), .read_request(req[2]), .addr_bus(addr),
        .read_grant(grant[2]), .data_bus(data[2]), .data_valid(valid[2]), .addr_err(err[2]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .reads_served(srv[2])
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Model: age = edges since the request was accepted; grant at age LAT, data from age LAT+2
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_act[i] <= 1'b0;
                m_srv[i] <= 16'd0;
            end else if (!m_act[i]) begin
                if (req[i]) begin
                    m_act[i] <= 1'b1;
                    m_age[i] <= 0;
                end
            end else if (m_age[i] == LAT[i] + 1) begin
                m_age[i]  <= m_age[i] + 1;
                m_err[i]  <= m_addr[i][15:8] != 8'd0;
                m_word[i] <= (m_addr[i][15:8] != 8'd0) ? 32'd0 :
                             (wr_en && wr_addr == m_addr[i][7:0]) ? wr_data : mmem[m_addr[i][7:0]];
            end else if (!req[i]) begin
                m_act[i] <= 1'b0;
            end else begin
                m_age[i] <= m_age[i] + 1;
                if (m_age[i] == LAT[i]) begin
                    m_addr[i] <= addr;
                    m_srv[i]  <= m_srv[i] + 16'd1;
                end
            end
        end
        if (preset) m_srv[1] <= 16'hFFFF;
        if (wr_en) mmem[wr_addr] <= wr_data;
    end

    // Every-cycle comparison of all outputs of all three instances
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                logic        v_e;
                v_e = m_act[i] && m_age[i] >= LAT[i] + 2;
                check($sformatf("cmp_grant%0d", i), 32'(grant[i]), 32'(m_act[i] && m_age[i] == LAT[i]));
                check($sformatf("cmp_valid%0d", i), 32'(valid[i]), 32'(v_e));
                check($sformatf("cmp_data%0d", i), data[i], v_e ? m_word[i] : 32'd0);
                check($sformatf("cmp_err%0d", i), 32'(err[i]), 32'(m_act[i] && m_age[i] == LAT[i] + 2 && m_err[i]));
                check($sformatf("cmp_served%0d", i), 32'(srv[i]), 32'(m_srv[i]));
            end
        end
    end

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Full read from a negedge; ends at a negedge with the request dropped for one edge
    task automatic do_read(input int i, input logic [15:0] a, input logic [31:0] w, input bit e, input bit fwd);
        addr = a;
        req[i] = 1'b1;
        for (int c = 0; c < LAT[i] + 3; c++) begin
            @(negedge clk);
            check($sformatf("grant%0d_c%0d", i, c), 32'(grant[i]), 32'(c == LAT[i]));
            if (fwd && c == LAT[i] + 1) begin
                wr_en = 1'b1;
                wr_addr = a[7:0];
                wr_data = 32'h1234_5678;
            end else begin
                wr_en = 1'b0;
            end
        end
        check($sformatf("valid%0d", i), 32'(valid[i]), 32'd1);
        check($sformatf("data%0d_%h", i, a), data[i], w);
        check($sformatf("err%0d_%h", i, a), 32'(err[i]), 32'(e));
        @(negedge clk);
        check($sformatf("err_pulse%0d", i), 32'(err[i]), 32'd0);
        check($sformatf("data_hold%0d", i), data[i], w);
        req[i] = 1'b0;
        @(negedge clk);
        check($sformatf("release_valid%0d", i), 32'(valid[i]), 32'd0);
        check($sformatf("release_data%0d", i), data[i], 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) req[i] = 1'b0;
        addr = 16'd0;
        wr_en = 1'b0;
        wr_addr = 8'd0;
        wr_data = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_grant", 32'(grant[0]), 32'd0);
        check("rst_valid", 32'(valid[0]), 32'd0);
        check("rst_data", data[0], 32'd0);
        check("rst_served", 32'(srv[0]), 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;
        preload(8'h10, 32'hCAFE_0001);
        preload(8'h03, 32'hA000_0003);
        preload(8'h04, 32'hB000_0004);
        preload(8'h07, 32'h1111_1111);
        do_read(0, 16'h0010, 32'hCAFE_0001, 1'b0, 1'b0);
        check("basic_served", 32'(srv[0]), 32'd1);
        do_read(0, 16'h0105, 32'd0, 1'b1, 1'b0);
        do_read(0, 16'h0007, 32'h1234_5678, 1'b0, 1'b1);
        check("served_after_three", 32'(srv[0]), 32'd3);
        do_read(1, 16'h0003, 32'hA000_0003, 1'b0, 1'b0);
        do_read(1, 16'h0004, 32'hB000_0004, 1'b0, 1'b0);
        check("lat0_served", 32'(srv[1]), 32'd2);
        req[2] = 1'b1;
        addr = 16'h0003;
        @(negedge clk);
        req[2] = 1'b0;
        repeat (8) begin
            @(negedge clk);
            check("abort_grant", 32'(grant[2]), 32'd0);
            check("abort_valid", 32'(valid[2]), 32'd0);
        end
        check("abort_served", 32'(srv[2]), 32'd0);
        addr = 16'h0010;
        req[0] = 1'b1;
        repeat (4) @(negedge clk);
        check("pre_rst_valid", 32'(valid[0]), 32'd1);
        rst = 1'b1;
        req[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("midrst_valid", 32'(valid[0]), 32'd0);
        check("midrst_data", data[0], 32'd0);
        check("midrst_served", 32'(srv[0]), 32'd0);
        check("midrst_served_l0", 32'(srv[1]), 32'd0);
        do_read(0, 16'h0010, 32'hCAFE_0001, 1'b0, 1'b0);
        check("post_rst_served", 32'(srv[0]), 32'd1);
        chk_en = 1'b0;
        @(posedge clk);
        #1;
        force u_l0.served_q = 16'hFFFF;
        preset = 1'b1;
        @(posedge clk);
        #1;
        release u_l0.served_q;
        preset = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        check("wrap_pre", 32'(srv[1]), 32'h0000_FFFF);
        do_read(1, 16'h0003, 32'hA000_0003, 1'b0, 1'b0);
        check("wrap_post", 32'(srv[1]), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
